cic_comp_fir: RTL and testbench

//  Compensation FIR stage placed directly after the 3-stage, decimate-by-32 CIC decimator.

---
 rtl/cic_comp_fir.sv | 129 ++++++++++++
 tb/tb_cic_comp_fir.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cic_comp_fir.sv
// 7-tap symmetric CIC droop-compensation FIR with one shared pre-add/multiply/accumulate datapath.
// Optional output clamp to [0, 2^DOUT_W-1] when CIC_COMP_SAT_EN is defined; default wraps.
module cic_comp_fir #(
   parameter int DIN_W  = 8,
   parameter int DOUT_W = 8,
   parameter int ACC_W  = 20,
   parameter int SHIFT  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIN_W-1:0]  din,
   input  logic              din_valid,
   input  logic              clr_ovr,
   output logic              busy,
   output logic [DOUT_W-1:0] dout,
   output logic              dout_valid,
   output logic              ovr
);

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                   state_q, state_d;
   logic [DIN_W-1:0]         x_q [0:6];
   logic [DIN_W-1:0]         x_d [0:6];
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [1:0]               k_q, k_d;
   logic [DOUT_W-1:0]        dout_q, dout_d;
   logic                     dout_valid_q, dout_valid_d;
   logic                     ovr_q, ovr_d;

   logic [DIN_W:0]           pre;
   logic signed [7:0]        coef;
   logic signed [ACC_W-1:0]  term;
   logic [DOUT_W-1:0]        y_out;

   // Symmetric taps share one multiply: pre-add the mirrored pair, centre tap stands alone.
   always_comb begin
      pre  = '0;
      coef = '0;
      case (k_q)
         2'd0: begin pre = {1'b0, x_q[0]} + {1'b0, x_q[6]}; coef = -8'sd2;  end
         2'd1: begin pre = {1'b0, x_q[1]} + {1'b0, x_q[5]}; coef = 8'sd4;   end
         2'd2: begin pre = {1'b0, x_q[2]} + {1'b0, x_q[4]}; coef = -8'sd10; end
         default: begin pre = {1'b0, x_q[3]}; coef = 8'sd80; end
      endcase
      term = $signed({{(ACC_W-DIN_W-1){1'b0}}, pre}) * $signed({{(ACC_W-8){coef[7]}}, coef});
   end

`ifdef CIC_COMP_SAT_EN
   logic signed [ACC_W-1:0] y;
   always_comb begin
      y = acc_q >>> SHIFT;
      if (y[ACC_W-1])
         y_out = '0;
      else if (|y[ACC_W-1:DOUT_W])
         y_out = '1;
      else
         y_out = y[DOUT_W-1:0];
   end
`else
   always_comb y_out = acc_q[SHIFT +: DOUT_W];
`endif

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      acc_d        = acc_q;
      k_d          = k_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      ovr_d        = ovr_q;
      if (clr_ovr)
         ovr_d = 1'b0;
      // DONE counts as busy, so a strobe on the return-to-IDLE edge is dropped too.
      if (din_valid && state_q != IDLE)
         ovr_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (din_valid) begin
               for (int unsigned i = 6; i > 0; i--)
                  x_d[i] = x_q[i-1];
               x_d[0]  = din;
               acc_d   = '0;
               k_d     = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = acc_q + term;
            k_d   = k_q + 2'd1;
            if (k_q == 2'd3)
               state_d = DONE;
         end
         DONE: begin
            dout_d       = y_out;
            dout_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         for (int unsigned i = 0; i < 7; i++)
            x_q[i] <= '0;
         acc_q        <= '0;
         k_q          <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         acc_q        <= acc_d;
         k_q          <= k_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         ovr_q        <= ovr_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign ovr        = ovr_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: reset, latency, impulse, DC, overrun and boundary vectors.
// Expected impulse outputs follow CIC_COMP_SAT_EN, matching the RTL build.
module tb_cic_comp_fir;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       din_valid;
   logic       clr_ovr;
   logic       busy;
   logic [7:0] dout;
   logic       dout_valid;
   logic       ovr;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] outs[$];
   logic       prev_dv  = 1'b0;
   int         n_before;

   cic_comp_fir #(.DIN_W(8), .DOUT_W(8), .ACC_W(20), .SHIFT(6)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_ovr(clr_ovr),
      .busy(busy), .dout(dout), .dout_valid(dout_valid), .ovr(ovr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] out_at(input int i);
      return (i < outs.size()) ? outs[i] : 8'hxx;
   endfunction

   // Capture every output pulse and make sure pulses are never back-to-back.
   always @(negedge clk) begin
      if (dout_valid) begin
         check("dv_single_cycle", {31'd0, prev_dv}, 32'd0);
         outs.push_back(dout);
      end
      prev_dv = dout_valid;
   end

   task automatic send(input logic [7:0] d, input int gap);
      @(negedge clk);
      din = d; din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   localparam logic [7:0] IMP_EXP [0:6] =
`ifdef CIC_COMP_SAT_EN
      '{8'd0, 8'd15, 8'd0, 8'd255, 8'd0, 8'd15, 8'd0};
   localparam logic [7:0] BND_EXP = 8'd0;
`else
      '{8'hF8, 8'h0F, 8'hD8, 8'h3E, 8'hD8, 8'h0F, 8'hF8};
   localparam logic [7:0] BND_EXP = 8'hE6;
`endif

   initial begin
      rst = 1'b1; din = '0; din_valid = 1'b0; clr_ovr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_dv", 32'(dout_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovr", 32'(ovr), 32'd0);
      rst = 1'b0;

      // Latency: strobe taken at E0, busy through E0+5, pulse after E0+5.
      @(negedge clk);
      din = 8'd255; din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0; din = '0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("lat_busy%0d", i), 32'(busy), 32'd1);
         check($sformatf("lat_nodv%0d", i), 32'(dout_valid), 32'd0);
         @(negedge clk);
      end
      check("lat_dv", 32'(dout_valid), 32'd1);
      check("lat_idle", 32'(busy), 32'd0);
      @(negedge clk);
      check("lat_dv_low", 32'(dout_valid), 32'd0);
      check("lat_one_pulse", 32'(outs.size()), 32'd1);

      // Impulse tail: six zeros.
      repeat (6) send(8'd0, 8);
      check("imp_count", 32'(outs.size()), 32'd7);
      for (int i = 0; i < 7; i++)
         check($sformatf("imp%0d", i), 32'(out_at(i)), 32'(IMP_EXP[i]));

      // DC 100 at the CIC rate; the 7th output onward is settled.
      repeat (8) send(8'd100, 32);
      check("dc_count", 32'(outs.size()), 32'd15);
      check("dc_7th", 32'(out_at(13)), 32'd100);
      check("dc_8th", 32'(out_at(14)), 32'd100);

      // Overrun: second strobe two cycles later is dropped.
      @(negedge clk); din = 8'd0; din_valid = 1'b1;
      @(negedge clk); din_valid = 1'b0;
      @(negedge clk); din = 8'd200; din_valid = 1'b1;
      @(negedge clk); din_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("ovr_set", 32'(ovr), 32'd1);
      check("ovr_one_pulse", 32'(outs.size()), 32'd16);
      check("ovr_out", 32'(out_at(15)), 32'd103);

      // clr_ovr together with a fresh overrun keeps the flag set.
      @(negedge clk); din = 8'd100; din_valid = 1'b1;
      @(negedge clk); din_valid = 1'b0;
      @(negedge clk); din = 8'd7; din_valid = 1'b1; clr_ovr = 1'b1;
      @(negedge clk); din_valid = 1'b0; clr_ovr = 1'b0;
      check("clr_vs_ovr", 32'(ovr), 32'd1);
      repeat (10) @(negedge clk);
      check("clr_pulses", 32'(outs.size()), 32'd17);
      check("clr_out", 32'(out_at(16)), 32'd93);
      @(negedge clk); clr_ovr = 1'b1;
      @(negedge clk); clr_ovr = 1'b0;
      check("clr_alone", 32'(ovr), 32'd0);

      // Boundary: strobe on the DONE edge dropped, next cycle accepted.
      @(negedge clk); din = 8'd50; din_valid = 1'b1;
      @(negedge clk); din_valid = 1'b0;
      repeat (4) @(negedge clk);
      din = 8'd250; din_valid = 1'b1;
      @(negedge clk); din = 8'd10;
      @(negedge clk); din_valid = 1'b0;
      check("bnd_ovr", 32'(ovr), 32'd1);
      repeat (10) @(negedge clk);
      check("bnd_pulses", 32'(outs.size()), 32'd19);
      check("bnd_first", 32'(out_at(17)), 32'd117);
      check("bnd_second", 32'(out_at(18)), 32'(BND_EXP));

      // Reset held mid-MAC.
      @(negedge clk); din = 8'd9; din_valid = 1'b1;
      @(negedge clk); din_valid = 1'b0;
      @(negedge clk); rst = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_dout", 32'(dout), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ovr", 32'(ovr), 32'd0);
      rst = 1'b0;
      n_before = outs.size();
      repeat (10) @(negedge clk);
      check("mid_rst_no_dv", 32'(outs.size()), 32'(n_before));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
